// File: rtl/btb_pkg.sv
// Shared types and address-slicing helpers for the 2-way set-associative
// branch target buffer.
package btb_pkg;

   localparam int BTB_INDEX_BITS = 6;
   localparam int BTB_WAYS       = 2;

   // The tag field is sized for the widest possible tag (30 bits of word
   // address); narrower tags are zero-extended so comparisons stay exact.
   typedef struct packed {
      logic        valid;
      logic [29:0] tag;
      logic [29:0] target;
   } btb_entry_t;

   function automatic logic [29:0] btb_index(input logic [29:0] pc_word,
                                             input int          index_bits);
      return pc_word & ((30'd1 << index_bits) - 30'd1);
   endfunction

   function automatic logic [29:0] btb_tag(input logic [29:0] pc_word,
                                           input int          index_bits);
      return pc_word >> index_bits;
   endfunction

endpackage

// File: rtl/btb_way_select.sv
// Way arbitration for one BTB set: resolves the hitting way (way 0 wins a
// double hit) and the allocation victim (first invalid way, else LRU).
module btb_way_select (
   input  logic [1:0] valid,
   input  logic [1:0] hit,
   input  logic       lru,
   output logic       hit_any,
   output logic       hit_way,
   output logic       victim_way
);

   always_comb begin
      hit_any = |hit;
      hit_way = ~hit[0];
      if (!valid[0]) begin
         victim_way = 1'b0;
      end else if (!valid[1]) begin
         victim_way = 1'b1;
      end else begin
         victim_way = lru;
      end
   end

endmodule

// File: rtl/branch_target_buffer.sv
// Fetch-stage branch target buffer: combinational lookup of pcF, Decode-stage
// copy of the result, and training from the Memory-stage resolved branch.
module branch_target_buffer
   import btb_pkg::*;
#(
   parameter int INDEX_BITS = BTB_INDEX_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallD,
   input  logic        flushD,
   input  logic [31:0] pcF,
   output logic        btb_hitF,
   output logic [31:0] btb_targetF,
   output logic        btb_hitD,
   output logic [31:0] btb_targetD,
   input  logic        branchM,
   input  logic [31:0] pcM,
   input  logic        actual_takeM,
   input  logic [31:0] actual_targetM
);

   localparam int SETS = 1 << INDEX_BITS;

   btb_entry_t [SETS-1:0][BTB_WAYS-1:0] entry_q, entry_d;
   logic       [SETS-1:0]               lru_q, lru_d;
   logic                                hitd_q, hitd_d;
   logic       [31:0]                   targetd_q, targetd_d;

   logic [INDEX_BITS-1:0] lkp_set, upd_set;
   logic [29:0]           lkp_tag, upd_tag;
   logic [1:0]            lkp_valid, lkp_hit, upd_valid, upd_hit;
   logic                  lkp_hit_any, lkp_hit_way, lkp_victim;
   logic                  upd_hit_any, upd_hit_way, upd_victim;

   assign lkp_set = INDEX_BITS'(btb_index(pcF[31:2], INDEX_BITS));
   assign lkp_tag = btb_tag(pcF[31:2], INDEX_BITS);
   assign upd_set = INDEX_BITS'(btb_index(pcM[31:2], INDEX_BITS));
   assign upd_tag = btb_tag(pcM[31:2], INDEX_BITS);

   // Both paths read the registered table, so a same-cycle update is never
   // visible to the lookup (no bypass).
   always_comb begin
      lkp_valid = '0;
      lkp_hit   = '0;
      upd_valid = '0;
      upd_hit   = '0;
      for (int w = 0; w < BTB_WAYS; w++) begin
         lkp_valid[w] = entry_q[lkp_set][w].valid;
         lkp_hit[w]   = entry_q[lkp_set][w].valid && (entry_q[lkp_set][w].tag == lkp_tag);
         upd_valid[w] = entry_q[upd_set][w].valid;
         upd_hit[w]   = entry_q[upd_set][w].valid && (entry_q[upd_set][w].tag == upd_tag);
      end
   end

   btb_way_select u_lkp_sel (
      .valid      (lkp_valid),
      .hit        (lkp_hit),
      .lru        (lru_q[lkp_set]),
      .hit_any    (lkp_hit_any),
      .hit_way    (lkp_hit_way),
      .victim_way (lkp_victim)
   );

   btb_way_select u_upd_sel (
      .valid      (upd_valid),
      .hit        (upd_hit),
      .lru        (lru_q[upd_set]),
      .hit_any    (upd_hit_any),
      .hit_way    (upd_hit_way),
      .victim_way (upd_victim)
   );

   assign btb_hitF    = lkp_hit_any;
   assign btb_targetF = lkp_hit_any ? {entry_q[lkp_set][lkp_hit_way].target, 2'b00} : 32'd0;

   // Only taken branches train the table; not-taken outcomes leave both the
   // entry and the replacement state untouched.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      entry_d = entry_q;
      lru_d   = lru_q;
      if (branchM && actual_takeM) begin
         if (upd_hit_any) begin
            entry_d[upd_set][upd_hit_way].target = actual_targetM[31:2];
            lru_d[upd_set]                       = ~upd_hit_way;
         end else begin
            entry_d[upd_set][upd_victim].valid  = 1'b1;
            entry_d[upd_set][upd_victim].tag    = upd_tag;
            entry_d[upd_set][upd_victim].target = actual_targetM[31:2];
            lru_d[upd_set]                      = ~upd_victim;
         end
      end
   end

   always_comb begin
      hitd_d    = hitd_q;
      targetd_d = targetd_q;
      if (flushD) begin
         hitd_d    = 1'b0;
         targetd_d = 32'd0;
      end else if (!stallD) begin
         hitd_d    = btb_hitF;
         targetd_d = btb_targetF;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         // NOTE: only the valid bits are reset; tag and target are don't-care while invalid.
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < BTB_WAYS; w++) begin
               entry_q[s][w].valid <= 1'b0;
            end
         end
         lru_q     <= '0;
         hitd_q    <= 1'b0;
         targetd_q <= 32'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         entry_q   <= entry_d;
         lru_q     <= lru_d;
         hitd_q    <= hitd_d;
         targetd_q <= targetd_d;
      end
   end

   assign btb_hitD    = hitd_q;
   assign btb_targetD = targetd_q;

   // Byte-offset bits and the lookup-side victim are intentionally unused.
   logic unused_bits;
   assign unused_bits = ^{pcF[1:0], pcM[1:0], actual_targetM[1:0], lkp_victim};

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: stimulus pushes expected F and D
// results into a scoreboard queue; a negedge monitor pops and compares.
module tb_branch_target_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallD, flushD;
   logic [31:0] pcF;
   logic        btb_hitF, btb_hitD;
   logic [31:0] btb_targetF, btb_targetD;
   logic        branchM, actual_takeM;
   logic [31:0] pcM, actual_targetM;

   branch_target_buffer #(.INDEX_BITS(6)) dut (
      .clk            (clk),
      .rst            (rst),
      .stallD         (stallD),
      .flushD         (flushD),
      .pcF            (pcF),
      .btb_hitF       (btb_hitF),
      .btb_targetF    (btb_targetF),
      .btb_hitD       (btb_hitD),
      .btb_targetD    (btb_targetD),
      .branchM        (branchM),
      .pcM            (pcM),
      .actual_takeM   (actual_takeM),
      .actual_targetM (actual_targetM)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      bit          is_d;
      string       name;
      logic        hit;
      logic [31:0] tgt;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic        d_hit_m = 1'b0;
   logic [31:0] d_tgt_m = 32'd0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: the DUT presents F and D results every cycle; compare whatever is due.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         logic        got_hit;
         logic [31:0] got_tgt;
         e       = sb.pop_front();
         got_hit = e.is_d ? btb_hitD : btb_hitF;
         got_tgt = e.is_d ? btb_targetD : btb_targetF;
         n_cmp++;
         if (e.cyc != cyc || got_hit !== e.hit || got_tgt !== e.tgt) begin
            n_bad++;
            $display("FAIL %s%s (cycle %0d, due %0d): got hit=%b target=%h, expected hit=%b target=%h",
                     e.name, e.is_d ? "_D" : "_F", cyc, e.cyc, got_hit, got_tgt, e.hit, e.tgt);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle of stimulus with the expected Fetch result; the Decode
   // expectation comes from a small register model of the D stage.
   task automatic step(input string name, input logic rstv, input logic stall, input logic flush,
                       input logic [31:0] pcf, input logic br, input logic [31:0] pcm,
                       input logic take, input logic [31:0] tgtm,
                       input logic exp_hit, input logic [31:0] exp_tgt);
      rst            = rstv;
      stallD         = stall;
      flushD         = flush;
      pcF            = pcf;
      branchM        = br;
      pcM            = pcm;
      actual_takeM   = take;
      actual_targetM = tgtm;
      sb.push_back('{cyc: cyc, is_d: 1'b0, name: name, hit: exp_hit, tgt: exp_tgt});
      sb.push_back('{cyc: cyc, is_d: 1'b1, name: name, hit: d_hit_m, tgt: d_tgt_m});
      if (!rstv || flush) begin
         d_hit_m = 1'b0;
         d_tgt_m = 32'd0;
      end else if (!stall) begin
         d_hit_m = exp_hit;
         d_tgt_m = exp_tgt;
      end
      tick();
   endtask

   task automatic look(input string name, input logic [31:0] pcf,
                       input logic exp_hit, input logic [31:0] exp_tgt);
      step(name, 1'b1, 1'b0, 1'b0, pcf, 1'b0, 32'd0, 1'b0, 32'd0, exp_hit, exp_tgt);
   endtask

   task automatic train(input string name, input logic [31:0] pcf, input logic [31:0] pcm,
                        input logic take, input logic [31:0] tgtm,
                        input logic exp_hit, input logic [31:0] exp_tgt);
      step(name, 1'b1, 1'b0, 1'b0, pcf, 1'b1, pcm, take, tgtm, exp_hit, exp_tgt);
   endtask

   initial begin
      rst = 1'b0; stallD = 1'b0; flushD = 1'b0; pcF = 32'h0040_0010;
      branchM = 1'b0; pcM = 32'd0; actual_takeM = 1'b0; actual_targetM = 32'd0;
      tick();

      // Reset state and first allocation with no same-cycle bypass
      step("rst_lookup", 1'b0, 1'b0, 1'b0, 32'h0040_0010, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      train("same_cycle", 32'h0040_0010, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'd0);
      look("hit_after",   32'h0040_0010, 1'b1, 32'h0040_0100);
      look("other_tag",   32'h0000_0010, 1'b0, 32'd0);

      // Not-taken training: no allocation on miss, no change on hit
      train("nt_miss_upd", 32'h0000_0820, 32'h0000_0820, 1'b0, 32'h1234_0000, 1'b0, 32'd0);
      look("nt_no_alloc",  32'h0000_0820, 1'b0, 32'd0);
      train("fill_way1",   32'h0000_0010, 32'h0000_0010, 1'b1, 32'h0000_0500, 1'b0, 32'd0);
      train("nt_hit_upd",  32'h0000_0010, 32'h0040_0010, 1'b0, 32'h0BAD_0000, 1'b1, 32'h0000_0500);
      train("nt_hit_keep", 32'h0040_0010, 32'h0000_0110, 1'b1, 32'h0000_0603, 1'b1, 32'h0040_0100);
      look("lru_evict0",   32'h0040_0010, 1'b0, 32'd0);
      look("new_way0",     32'h0000_0110, 1'b1, 32'h0000_0600);
      look("kept_way1",    32'h0000_0010, 1'b1, 32'h0000_0500);

      // Reset overrides a same-cycle update and invalidates everything
      step("rst_mid", 1'b0, 1'b0, 1'b0, 32'h0000_0110, 1'b1, 32'h0040_0010, 1'b1, 32'h0000_0777,
           1'b1, 32'h0000_0600);
      look("rst_no_write", 32'h0040_0010, 1'b0, 32'd0);
      look("rst_miss_a",   32'h0000_0110, 1'b0, 32'd0);
      look("rst_miss_b",   32'h0000_0010, 1'b0, 32'd0);

      // Three taken branches aliasing to set 4
      train("alias_a", 32'h0000_0110, 32'h0000_0010, 1'b1, 32'h0000_1000, 1'b0, 32'd0);
      train("alias_b", 32'h0000_0010, 32'h0000_0110, 1'b1, 32'h0000_2000, 1'b1, 32'h0000_1000);
      train("alias_c", 32'h0000_0110, 32'h0000_0210, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_2000);
      look("alias_evicted", 32'h0000_0010, 1'b0, 32'd0);
      look("alias_keep_b",  32'h0000_0110, 1'b1, 32'h0000_2000);
      look("alias_new_c",   32'h0000_0210, 1'b1, 32'h0000_3000);

      // Stall holds D for three cycles, then flush together with stall clears it
      step("stall1", 1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      step("stall2", 1'b1, 1'b1, 1'b0, 32'h0000_0110, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0000_2000);
      step("stall3", 1'b1, 1'b1, 1'b0, 32'h0040_0010, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      step("flush_stall", 1'b1, 1'b1, 1'b1, 32'h0000_0110, 1'b0, 32'd0, 1'b0, 32'd0,
           1'b1, 32'h0000_2000);
      look("post_flush",  32'h0000_0210, 1'b1, 32'h0000_3000);
      look("reload",      32'h0000_0110, 1'b1, 32'h0000_2000);
      look("final",       32'h0000_0000, 1'b0, 32'd0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Fetch-stage branch target buffer that runs alongside the global-history direction predictor. Each cycle it looks up `pcF` and returns a hit flag and a predicted target address, which the next-PC mux uses together with `pred_takeF`. A pipelined copy of the result is carried into Decode under the same stall/flush rules as the direction prediction. The table is trained in Memory with the resolved outcome and target of every branch.

## Interface
Parameters:
- `INDEX_BITS`, 6: set-index width; the table has 2^INDEX_BITS sets of 2 ways each.
- `TAG_BITS`, 30-INDEX_BITS: derived, not overridable; tag is `pc[31:INDEX_BITS+2]`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `stallD`  in  1  hold the Decode-stage registers.
- `flushD`  in  1  clear the Decode-stage registers.
- `pcF`  in  32  Fetch PC.
- `btb_hitF`  out  1  combinational hit for `pcF`.
- `btb_targetF`  out  32  combinational predicted target; 0 when `btb_hitF`=0.
- `btb_hitD`  out  1  registered `btb_hitF`.
- `btb_targetD`  out  32  registered `btb_targetF`.
- `branchM`  in  1  the Memory-stage instruction is a branch or jump with a resolved target.
- `pcM`  in  32  PC of the Memory-stage instruction.
- `actual_takeM`  in  1  the branch was actually taken.
- `actual_targetM`  in  32  resolved target; bits [1:0] are ignored.

## Operation
- Storage per set: `valid[1:0]`, `tag[1:0]` (TAG_BITS each), `target[1:0]` (30 bits = addr[31:2]), and one `lru` bit naming the next victim way.
- Lookup:
  - Set = `pcF[INDEX_BITS+1:2]`.
  - Way w hits when `valid[w]` and `tag[w] == pcF[31:INDEX_BITS+2]`.
  - `btb_targetF = {target[w], 2'b00}` for the hitting way.
  - The update rules guarantee at most one hitting way. If both ever hit, way 0 wins.
- Update, on a rising edge with `branchM`=1 and `rst`=1, indexed by `pcM`:
  - Hit in way w, taken: write `target[w]`; set `lru` = ~w.
  - Hit in way w, not taken: no change to the entry or to `lru`.
  - Miss, taken: allocate. Pick way 0 if invalid, else way 1 if invalid, else way `lru`. Write valid=1, tag, and target; set `lru` = ~allocated way.
  - Miss, not taken: no change.
- No lookup bypass. A lookup in the same cycle as an update to the same set sees the pre-update contents.
- Decode registers, priority rst > flushD > stallD:
  - `rst`=0 or `flushD`=1: both registers are cleared to 0.
  - `stallD`=1: both registers hold.
  - Otherwise: load the F values.

## Timing
- Lookup is zero latency (combinational from `pcF`).
- The D outputs have 1-cycle latency.
- An update written at edge N is visible to lookups from cycle N+1 onward.
- Reset: all `valid` = 0, all `lru` = 0, `btb_hitD` = 0, `btb_targetD` = 0.
- Tag and target arrays are not reset (don't-care while invalid).
- Reset asserted mid-operation overrides any same-cycle update. After release, every lookup misses.
- `flushD` and `stallD` asserted together: flush wins.

## Structure
- Shared package `btb_pkg`:
  - `BTB_INDEX_BITS` default.
  - Function `btb_index(pc)`.
  - Function `btb_tag(pc)`.
  - typedef `btb_entry_t {valid, tag, target}`.
- One sub-module is natural: `btb_way_select`, combinational. It maps `{valid[1:0], hit[1:0], lru}` to the hitting way and the victim way, and is shared by the lookup and update paths.
- Arrays are flop-based, for the single-cycle reset of the valid bits.

## Test plan
- Reset, then `pcF`=0x0040_0010 → `btb_hitF`=0, `btb_targetF`=0; next cycle `btb_hitD`=0.
- Update `pcM`=0x0040_0010, taken, target 0x0040_0100 → lookup of 0x0040_0010 the next cycle gives hit=1, target 0x0040_0100. Same-cycle lookup gives hit=0.
- Three taken branches aliasing to set 4 (0x0000_0010, 0x0000_0110, 0x0000_0210) → the first two fill ways 0 and 1; the third evicts way 0 (lru=0); 0x0000_0010 then misses and the other two hit.
- Not-taken update for a missing PC → no allocation. Not-taken update for a hitting PC → target unchanged, `lru` unchanged.
- `stallD`=1 for 3 cycles while `pcF` changes → D outputs hold their values. Then `flushD`=1 together with `stallD`=1 → D outputs are 0 the next cycle.
- `rst`=0 in the same cycle as a taken `branchM` update → no entry written; subsequent lookups miss.
